// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 8-opcode core:
//   - seq_state_t : instruction sequencer state encoding
//   - OP_*        : 3-bit opcode constants
//   - PC_W_DEF / OFF_W_DEF : default program-counter and branch-offset widths
//   - small helper functions used by the sequencer and by decoder-side code
// ---------------------------------------------------------------------------
package core_pkg;

   localparam int PC_W_DEF  = 8;
   localparam int OFF_W_DEF = 5;

   localparam logic [2:0] OP_SB  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_CPY = 3'b101;
   localparam logic [2:0] OP_SL  = 3'b110;
   localparam logic [2:0] OP_BNE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } seq_state_t;

   // A run is in progress in every state between FETCH and WB inclusive.
   function automatic logic state_is_busy(seq_state_t s);
      return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
             (s == S_MEM)   || (s == S_WB);
   endfunction

   // Opcode classification, for decoder-side code sharing this package.
   function automatic logic op_uses_mem(logic [2:0] op);
      return (op == OP_SB) || (op == OP_LB);
   endfunction

   function automatic logic op_writes_reg(logic [2:0] op);
      return (op == OP_LB)  || (op == OP_ADD) || (op == OP_AND) ||
             (op == OP_XOR) || (op == OP_CPY) || (op == OP_SL);
   endfunction

   function automatic logic op_is_branch(logic [2:0] op);
      return op == OP_BNE;
   endfunction

endpackage : core_pkg

// File: rtl/instr_sequencer_pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter register with increment / relative-branch update.
// All arithmetic is modulo 2^PC_W, so branches and increments wrap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pc -> 0)
//   clr        : synchronous clear to 0 (start of a run), has priority
//   upd        : apply the update this cycle (WB)
//   br_take    : 1 -> pc + sign-extended br_off, 0 -> pc + 1
//   br_off     : signed two's-complement branch offset
//   pc         : current program counter
// ---------------------------------------------------------------------------
module pc_unit
   import core_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             upd,
   input  logic             br_take,
   input  logic [OFF_W-1:0] br_off,
   output logic [PC_W-1:0]  pc
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] off_ext;

   // Offset is narrower than the PC; replicate its sign bit.
   assign off_ext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

   always_comb begin
      pc_d = pc_q;
      if (clr) begin
         pc_d = '0;
      end else if (upd) begin
         if (br_take) begin
            pc_d = pc_q + off_ext;
         end else begin
            pc_d = pc_q + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule : pc_unit

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle sequencer for the 8-opcode core. Steps each instruction
// through FETCH, DECODE, EXEC, optional MEM and WB, gates decoder flags into
// single-cycle datapath enables, runs the data-memory req/ack handshake with
// a timeout, and counts retired instructions.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : level, begins a run from pc=0 when IDLE or HALT
//   halt_req       : external stop, only looked at in WB
//   ctl_branch/ctl_read_mem/ctl_write_mem/ctl_write_reg : decoder flags
//   branch_taken   : ALU compare result (valid in EXEC)
//   branch_off     : signed branch offset (valid in EXEC)
//   mem_ack        : data-memory completion (ignored outside MEM)
//   pc             : instruction address
//   ir_load        : IR capture enable (DECODE)
//   mem_req/mem_we : data-memory request / write qualifier (MEM)
//   reg_we         : register-file write enable (WB)
//   busy           : run in progress
//   done           : run ended normally (held until next start)
//   mem_err        : memory timeout (held until next start)
//   instr_count    : retired instructions this run, saturating
// ---------------------------------------------------------------------------
module instr_sequencer
   import core_pkg::*;
#(
   parameter int PC_W        = PC_W_DEF,
   parameter int OFF_W       = OFF_W_DEF,
   parameter int PROG_END    = 255,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             ctl_branch,
   input  logic             ctl_read_mem,
   input  logic             ctl_write_mem,
   input  logic             ctl_write_reg,
   input  logic             branch_taken,
   input  logic [OFF_W-1:0] branch_off,
   input  logic             mem_ack,
   output logic [PC_W-1:0]  pc,
   output logic             ir_load,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_we,
   output logic             busy,
   output logic             done,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   seq_state_t       state_q,  state_d;
   logic             br_take_q, br_take_d;
   logic [OFF_W-1:0] br_off_q,  br_off_d;
   logic [WAIT_W-1:0] wait_q,   wait_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             done_q,    done_d;
   logic             err_q,     err_d;

   logic             pc_clr;
   logic             pc_upd;

   // ------------------------------------------------------------------
   // Next-state and control
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      br_take_d = br_take_q;
      br_off_d  = br_off_q;
      wait_d    = wait_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      err_d     = err_q;
      pc_clr    = 1'b0;
      pc_upd    = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_clr  = 1'b1;
               cnt_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end

         S_FETCH: begin
            state_d = S_DECODE;
         end

         S_DECODE: begin
            state_d = S_EXEC;
         end

         S_EXEC: begin
            // Capture the branch decision now; the ALU result is only
            // guaranteed valid in this cycle.
            br_take_d = ctl_branch & branch_taken;
            br_off_d  = branch_off;
            wait_d    = '0;
            if (ctl_read_mem || ctl_write_mem) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM: begin
            // An ack in the last allowed cycle still wins over the timeout.
            if (mem_ack) begin
               state_d = S_WB;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_WB: begin
            pc_upd = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // End-of-program test uses the pc of the instruction retiring
            // now, not the updated one.
            if ((pc == PC_W'(PROG_END)) || halt_req) begin
               state_d = S_HALT;
               done_d  = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         br_take_q <= 1'b0;
         br_off_q  <= '0;
         wait_q    <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         br_take_q <= br_take_d;
         br_off_q  <= br_off_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // ------------------------------------------------------------------
   // Program counter
   // ------------------------------------------------------------------
   pc_unit #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_pc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (pc_clr),
      .upd     (pc_upd),
      .br_take (br_take_q),
      .br_off  (br_off_q),
      .pc      (pc)
   );

   // ------------------------------------------------------------------
   // Outputs: decoded from the state register so that an asynchronous
   // reset drops every enable in the same instant.
   // ------------------------------------------------------------------
   assign ir_load     = (state_q == S_DECODE);
   assign mem_req     = (state_q == S_MEM);
   assign mem_we      = (state_q == S_MEM) & ctl_write_mem;
   assign reg_we      = (state_q == S_WB) & ctl_write_reg;
   assign busy        = state_is_busy(state_q);
   assign done        = done_q;
   assign mem_err     = err_q;
   assign instr_count = cnt_q;

endmodule : instr_sequencer

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed and randomized stimulus for instr_sequencer. The reference model
// tracks pc, retired count, done and mem_err per instruction from the
// architectural rules and checks every cycle's outputs.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   localparam int PC_W        = 8;
   localparam int OFF_W       = 5;
   localparam int PROG_END    = 255;
   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             halt_req;
   logic             ctl_branch;
   logic             ctl_read_mem;
   logic             ctl_write_mem;
   logic             ctl_write_reg;
   logic             branch_taken;
   logic [OFF_W-1:0] branch_off;
   logic             mem_ack;
   logic [PC_W-1:0]  pc;
   logic             ir_load;
   logic             mem_req;
   logic             mem_we;
   logic             reg_we;
   logic             busy;
   logic             done;
   logic             mem_err;
   logic [CNT_W-1:0] instr_count;

   instr_sequencer #(
      .PC_W        (PC_W),
      .OFF_W       (OFF_W),
      .PROG_END    (PROG_END),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .halt_req      (halt_req),
      .ctl_branch    (ctl_branch),
      .ctl_read_mem  (ctl_read_mem),
      .ctl_write_mem (ctl_write_mem),
      .ctl_write_reg (ctl_write_reg),
      .branch_taken  (branch_taken),
      .branch_off    (branch_off),
      .mem_ack       (mem_ack),
      .pc            (pc),
      .ir_load       (ir_load),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .reg_we        (reg_we),
      .busy          (busy),
      .done          (done),
      .mem_err       (mem_err),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state
   int m_pc;
   int m_cnt;
   bit m_done;
   bit m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet_outs(input string tag);
      check({tag, ".ir_load"}, 32'(ir_load), 32'd0);
      check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
      check({tag, ".mem_we"},  32'(mem_we),  32'd0);
      check({tag, ".reg_we"},  32'(reg_we),  32'd0);
   endtask

   // Called at a negedge while the DUT is IDLE or HALT; returns at the
   // negedge of the FETCH cycle.
   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      m_pc   = 0;
      m_cnt  = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   // One instruction, entered at the negedge of FETCH. ack_at: MEM cycle
   // index (0-based) at which mem_ack is raised, <0 for never. rst_at: MEM
   // cycle index at which reset is asserted, <0 for never.
   task automatic do_instr(input bit rd, input bit wr, input bit wreg, input bit br,
                           input bit taken, input logic [OFF_W-1:0] off,
                           input int ack_at, input bit halt_exec, input bit halt_wb,
                           input int rst_at, output bit ended);
      bit exp_halt;
      int k;
      int sext_off;
      ended         = 1'b0;
      ctl_read_mem  = rd;
      ctl_write_mem = wr;
      ctl_write_reg = wreg;
      ctl_branch    = br;
      branch_taken  = 1'b0;
      halt_req      = 1'b0;
      mem_ack       = 1'($urandom_range(0, 1));
      // FETCH
      #1;
      check("fetch.pc",      32'(pc),          32'(m_pc));
      check("fetch.busy",    32'(busy),        32'd1);
      check("fetch.done",    32'(done),        32'(m_done));
      check("fetch.mem_err", 32'(mem_err),     32'(m_err));
      check("fetch.count",   32'(instr_count), 32'(m_cnt));
      check_quiet_outs("fetch");
      // DECODE: start here must be ignored
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      start   = 1'($urandom_range(0, 1));
      #1;
      check("decode.ir_load", 32'(ir_load), 32'd1);
      check("decode.busy",    32'(busy),    32'd1);
      // EXEC
      @(negedge clk);
      start        = 1'b0;
      branch_taken = taken;
      branch_off   = off;
      halt_req     = halt_exec;
      mem_ack      = 1'($urandom_range(0, 1));
      #1;
      check("exec.busy", 32'(busy), 32'd1);
      check_quiet_outs("exec");
      @(negedge clk);
      // The latched values must be used from here on, not live inputs.
      branch_taken = ~taken;
      branch_off   = OFF_W'($urandom);
      halt_req     = 1'b0;
      if (rd || wr) begin
         k = 0;
         while (1) begin
            mem_ack = (k == ack_at);
            #1;
            check("mem.mem_req", 32'(mem_req), 32'd1);
            check("mem.mem_we",  32'(mem_we),  32'(wr));
            check("mem.reg_we",  32'(reg_we),  32'd0);
            check("mem.ir_load", 32'(ir_load), 32'd0);
            check("mem.busy",    32'(busy),    32'd1);
            if (k == rst_at) begin
               rst_n   = 1'b0;
               mem_ack = 1'b0;
               #1;
               check("rst.pc",      32'(pc),          32'd0);
               check("rst.busy",    32'(busy),        32'd0);
               check("rst.done",    32'(done),        32'd0);
               check("rst.mem_err", 32'(mem_err),     32'd0);
               check("rst.count",   32'(instr_count), 32'd0);
               check_quiet_outs("rst");
               ended = 1'b1;
               return;
            end
            if (k == ack_at) begin
               @(negedge clk);
               break;
            end
            if (k == MEM_TIMEOUT - 1) begin
               @(negedge clk);
               mem_ack = 1'b0;
               m_err   = 1'b1;
               #1;
               check("tmo.busy",    32'(busy),        32'd0);
               check("tmo.mem_err", 32'(mem_err),     32'd1);
               check("tmo.done",    32'(done),        32'd0);
               check("tmo.count",   32'(instr_count), 32'(m_cnt));
               check("tmo.pc",      32'(pc),          32'(m_pc));
               check_quiet_outs("tmo");
               ended = 1'b1;
               return;
            end
            k++;
            @(negedge clk);
         end
      end
      // WB
      halt_req = halt_wb;
      mem_ack  = 1'($urandom_range(0, 1));
      #1;
      check("wb.reg_we",  32'(reg_we),      32'(wreg));
      check("wb.mem_req", 32'(mem_req),     32'd0);
      check("wb.ir_load", 32'(ir_load),     32'd0);
      check("wb.busy",    32'(busy),        32'd1);
      check("wb.count",   32'(instr_count), 32'(m_cnt));
      exp_halt = (m_pc == PROG_END) || halt_wb;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      sext_off = off[OFF_W-1] ? int'(off) - (1 << OFF_W) : int'(off);
      if (br && taken) m_pc = (m_pc + sext_off) & ((1 << PC_W) - 1);
      else             m_pc = (m_pc + 1) & ((1 << PC_W) - 1);
      @(negedge clk);
      halt_req = 1'b0;
      mem_ack  = 1'b0;
      #1;
      check("post.pc",    32'(pc),          32'(m_pc));
      check("post.count", 32'(instr_count), 32'(m_cnt));
      check("post.busy",  32'(busy),        32'(!exp_halt));
      check("post.done",  32'(done),        32'(exp_halt));
      check("post.reg_we", 32'(reg_we),     32'd0);
      if (exp_halt) begin
         m_done = 1'b1;
         ended  = 1'b1;
      end
      $display("instr: rd=%0b wr=%0b wreg=%0b br=%0b tk=%0b off=%0d ack_at=%0d -> pc=%0d cnt=%0d halted=%0b",
               rd, wr, wreg, br, taken, off, ack_at, m_pc, m_cnt, exp_halt);
   endtask

   // Convenience wrappers
   task automatic alu_op(input bit halt_exec, input bit halt_wb, output bit ended);
      do_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, -1, halt_exec, halt_wb, -1, ended);
   endtask

   task automatic bne(input bit taken, input logic [OFF_W-1:0] off, output bit ended);
      do_instr(1'b0, 1'b0, 1'b0, 1'b1, taken, off, -1, 1'b0, 1'b0, -1, ended);
   endtask

   // Watchdog: the bench must always finish on its own.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ended;
      bit rd, wr, wreg, br, taken, hwb;
      logic [OFF_W-1:0] off;
      int ack_at;
      int op;

      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
      ctl_branch = 1'b0; ctl_read_mem = 1'b0; ctl_write_mem = 1'b0; ctl_write_reg = 1'b0;
      branch_taken = 1'b0; branch_off = '0; mem_ack = 1'b0;
      m_pc = 0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0;

      // Reset state
      @(negedge clk);
      #1;
      check("reset.pc",   32'(pc),   32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check_quiet_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      // IDLE holds without start
      repeat (3) begin
         @(negedge clk);
         #1;
         check("idle.busy", 32'(busy), 32'd0);
         check_quiet_outs("idle");
      end
      @(negedge clk);

      // Three ALU instructions, stop at pc=2
      start_run();
      alu_op(1'b0, 1'b0, ended);
      alu_op(1'b0, 1'b0, ended);
      alu_op(1'b0, 1'b1, ended);
      check("run3.ended", 32'(ended), 32'd1);
      check("run3.count", 32'(instr_count), 32'd3);

      // Branches at pc=5: taken -3, then not taken
      @(negedge clk);
      start_run();
      repeat (5) alu_op(1'b0, 1'b0, ended);
      bne(1'b1, 5'b11101, ended);
      check("bne_tk.pc", 32'(pc), 32'd2);
      repeat (3) alu_op(1'b0, 1'b0, ended);
      bne(1'b0, 5'b11101, ended);
      check("bne_nt.pc", 32'(pc), 32'd6);
      alu_op(1'b0, 1'b1, ended);

      // Wrap: 0 -> 255 via -1, then 255 + 2 -> 1; pc 255 ends the run
      @(negedge clk);
      start_run();
      bne(1'b1, 5'b11111, ended);
      check("wrap_dn.pc", 32'(pc), 32'd255);
      bne(1'b1, 5'b00010, ended);
      check("wrap_up.pc",    32'(pc),    32'd1);
      check("wrap_up.ended", 32'(ended), 32'd1);

      // Load acked in the third MEM cycle
      @(negedge clk);
      start_run();
      do_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 2, 1'b0, 1'b0, -1, ended);
      alu_op(1'b0, 1'b1, ended);

      // Store that is never acked -> timeout, then restart clears mem_err
      @(negedge clk);
      start_run();
      alu_op(1'b0, 1'b0, ended);
      do_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0, 1'b0, -1, ended);
      check("tmo.ended", 32'(ended), 32'd1);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("tmo.hold_err", 32'(mem_err), 32'd1);
      end
      @(negedge clk);
      start_run();
      alu_op(1'b0, 1'b1, ended);

      // halt_req in EXEC ignored; in WB at pc=4 stops with pc=5
      @(negedge clk);
      start_run();
      repeat (4) alu_op(1'b1, 1'b0, ended);
      check("halt_exec.ended", 32'(ended), 32'd0);
      alu_op(1'b0, 1'b1, ended);
      check("halt_wb.pc", 32'(pc), 32'd5);

      // Asynchronous reset in the middle of a MEM handshake
      @(negedge clk);
      start_run();
      do_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, -1, 1'b0, 1'b0, 1, ended);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      start_run();
      alu_op(1'b0, 1'b1, ended);

      // Randomized runs
      for (int run = 0; run < 30; run++) begin
         @(negedge clk);
         start_run();
         ended = 1'b0;
         for (int n = 0; n < 25 && !ended; n++) begin
            op   = int'($urandom_range(0, 7));
            rd   = (op == 1);
            wr   = (op == 0);
            wreg = (op >= 1) && (op <= 6);
            br   = (op == 7);
            if ($urandom_range(0, 15) == 0) begin
               rd = 1'b1;
               wr = 1'b1;
            end
            taken  = 1'($urandom_range(0, 1));
            off    = OFF_W'($urandom);
            ack_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, MEM_TIMEOUT - 1));
            hwb    = ($urandom_range(0, 11) == 0) || (n == 24);
            do_instr(rd, wr, wreg, br, taken, off, ack_at,
                     1'($urandom_range(0, 1)), hwb, -1, ended);
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_instr_sequencer
